// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } if_state_e;

    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
interface if_fetch_unit_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fetch_buffer.sv
// One-entry fetch buffer holding the word (and its address) offered to IF/ID.
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   i_load,
    input  logic                   i_consume,
    input  logic                   i_invalidate,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_pc,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc
);
    logic                   r_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_pc;

    // Invalidate beats load, load beats consume so a same-edge refill keeps the entry valid.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_valid <= 1'b0;
            r_instr <= INSTR_WIDTH'(NOP_INSTR);
            r_pc    <= '0;
        end else begin
            if (i_invalidate) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
                r_instr <= i_instr;
                r_pc    <= i_pc;
            end else if (i_consume) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, imem handshake, redirect drain and IF/ID hold/flush control.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   Clk,
    input  logic                   Reset,
    if_fetch_unit_if.master        imem,
    input  logic                   hazard_stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [INSTR_WIDTH-1:0] Instruction,
    output logic [PC_WIDTH-1:0]    PC,
    output logic                   IFID_writeOff,
    output logic                   flush
);
    if_state_e           r_state;
    if_state_e           w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [PC_WIDTH-1:0] r_redir_pc;
    logic [PC_WIDTH-1:0] w_redir_nxt;
    logic                r_pending;
    logic                w_req;
    logic                w_load;
    logic                w_consume;
    logic                w_buf_valid;
    logic [PC_WIDTH-1:0] w_tgt;

    assign w_tgt     = branch_target & PC_WIDTH'(ALIGN_MASK);
    assign w_consume = w_buf_valid & ~hazard_stall & ~branch_taken;

    // State, PC, redirect target and outstanding-request tracking.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_redir_pc <= RESET_PC;
            r_pending  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_redir_pc <= w_redir_nxt;
            r_pending  <= w_req & ~imem.imem_ready;
        end
    end

    // Next-state, PC update and request generation.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_redir_nxt = r_redir_pc;
        w_req       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            FETCH: begin
                w_req = r_pending | ~w_buf_valid | w_consume;
                if (branch_taken) begin
                    // A stalled request must finish at its original address before redirecting.
                    if (w_req & ~imem.imem_ready) begin
                        w_redir_nxt = w_tgt;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_pc_nxt = w_tgt;
                    end
                end else if (w_req & imem.imem_ready) begin
                    w_load   = 1'b1;
                    w_pc_nxt = r_pc + PC_WIDTH'(PC_INC);
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            DRAIN: begin
                w_req = 1'b1;
                if (imem.imem_ready) begin
                    w_pc_nxt    = branch_taken ? w_tgt : r_redir_pc;
                    w_state_nxt = FETCH;
                end else if (branch_taken) begin
                    w_redir_nxt = w_tgt;
                end else begin
                    w_redir_nxt = r_redir_pc;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // IF/ID control: reset, then branch, then stall, else bubble when nothing is buffered.
    always_comb begin
        IFID_writeOff = 1'b0;
        flush         = 1'b1;
        if (!Reset) begin
            IFID_writeOff = 1'b0;
            flush         = 1'b1;
        end else if (branch_taken) begin
            IFID_writeOff = 1'b0;
            flush         = 1'b1;
        end else if (hazard_stall) begin
            IFID_writeOff = 1'b1;
            flush         = 1'b0;
        end else begin
            IFID_writeOff = 1'b0;
            flush         = ~w_buf_valid;
        end
    end

    assign imem.imem_req  = w_req & Reset;
    assign imem.imem_addr = r_pc;

    if_fetch_buffer #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_fetch_buffer (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_load       (w_load),
        .i_consume    (w_consume),
        .i_invalidate (branch_taken),
        .i_instr      (imem.imem_rdata),
        .i_pc         (r_pc),
        .o_valid      (w_buf_valid),
        .o_instr      (Instruction),
        .o_pc         (PC)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a transaction-level fetch model.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        hazard_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        IFID_writeOff;
    logic        flush;

    int n_pass  = 0;
    int n_total = 0;

    // Model: next fetch address, word-ready flag, outstanding request, drain/redirect, program-order stream.
    logic [31:0] m_pc;
    logic        m_full;
    logic        m_wait;
    logic        m_drain;
    logic [31:0] m_redir;
    logic [31:0] m_seq_pc;

    always #5 Clk = ~Clk;

    if_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) u_imem ();

    if_fetch_unit #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .imem          (u_imem.master),
        .hazard_stall  (hazard_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .Instruction   (Instruction),
        .PC            (PC),
        .IFID_writeOff (IFID_writeOff),
        .flush         (flush)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
    endfunction

    assign u_imem.imem_rdata = mem_word(u_imem.imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_pc     = 32'h0000_0000;
        m_full   = 1'b0;
        m_wait   = 1'b0;
        m_drain  = 1'b0;
        m_redir  = 32'h0000_0000;
        m_seq_pc = 32'h0000_0000;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   {31'd0, u_imem.imem_req}, 32'd0);
        check_eq({tag, "_flush"}, {31'd0, flush},           32'd1);
        check_eq({tag, "_hold"},  {31'd0, IFID_writeOff},   32'd0);
        check_eq({tag, "_pc"},    PC,                       32'd0);
        check_eq({tag, "_instr"}, Instruction,              32'd0);
    endtask

    // Called at posedge+1: asserts reset, checks forced outputs, holds for n cycles, releases.
    task automatic apply_reset(input int n);
        Reset = 1'b0;
        u_imem.imem_ready = 1'($urandom_range(1, 0));
        #1;
        check_reset_outputs("rst");
        repeat (n) @(posedge Clk);
        #1;
        check_reset_outputs("rst_hold");
        Reset = 1'b1;
        model_reset();
    endtask

    // One clock: drive at posedge+1, check just before the next edge, then advance the model.
    task automatic cycle(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
        logic        e_req;
        logic        e_flush;
        logic        e_hold;
        logic [31:0] t;
        hazard_stall      = st;
        branch_taken      = br;
        branch_target     = tgt;
        u_imem.imem_ready = rdy;
        #3;
        t     = tgt & 32'hFFFF_FFFC;
        e_req = m_drain | m_wait | !m_full | (m_full & !st & !br);
        if (br) begin
            e_flush = 1'b1; e_hold = 1'b0;
        end else if (st) begin
            e_flush = 1'b0; e_hold = 1'b1;
        end else begin
            e_flush = !m_full; e_hold = 1'b0;
        end
        check_eq("req",   {31'd0, u_imem.imem_req}, {31'd0, e_req});
        if (e_req) check_eq("addr", u_imem.imem_addr, m_pc);
        check_eq("flush", {31'd0, flush},           {31'd0, e_flush});
        check_eq("hold",  {31'd0, IFID_writeOff},   {31'd0, e_hold});
        if (!e_flush && !e_hold) begin
            check_eq("stream_pc", PC,          m_seq_pc);
            check_eq("instr",     Instruction, mem_word(m_seq_pc));
            m_seq_pc = m_seq_pc + 32'd4;
        end
        if (br) m_seq_pc = t;

        if (m_drain) begin
            if (rdy) begin
                m_drain = 1'b0;
                m_pc    = br ? t : m_redir;
            end else if (br) begin
                m_redir = t;
            end
            m_wait = !rdy;
        end else begin
            if (br) begin
                m_full = 1'b0;
                if (e_req && !rdy) begin
                    m_drain = 1'b1;
                    m_redir = t;
                end else begin
                    m_pc = t;
                end
            end else if (e_req && rdy) begin
                m_full = 1'b1;
                m_pc   = m_pc + 32'd4;
            end else if (m_full && !st) begin
                m_full = 1'b0;
            end
            m_wait = e_req && !rdy;
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset             = 1'b0;
        hazard_stall      = 1'b0;
        branch_taken      = 1'b0;
        branch_target     = 32'd0;
        u_imem.imem_ready = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        apply_reset(3);

        // Back-to-back fetches, then a two-cycle stall with a buffered word.
        repeat (4) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Branch to 0x40 while the PC=4 word is buffered.
        apply_reset(1);
        repeat (2) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Slow memory at 0x8 with a redirect to 0x100 during the wait.
        apply_reset(1);
        repeat (2) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("after_drain_addr", u_imem.imem_addr, 32'h0000_0100);
        repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Alternating memory readiness.
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'd0, 1'(i % 2 == 0));

        // Reset asserted in the middle of a drain.
        apply_reset(1);
        cycle(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        apply_reset(2);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect to the last word of the address space; fetch wraps to 0.
        apply_reset(1);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        #3;
        check_eq("wrap_addr", u_imem.imem_addr, 32'h0000_0000);
        @(posedge Clk);
        #1;
        model_reset();
        apply_reset(1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299, 0) == 0) begin
                apply_reset(1);
            end else begin
                cycle(1'($urandom_range(99, 0) < 20),
                      1'($urandom_range(99, 0) < 10),
                      ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFC : $urandom(),
                      1'($urandom_range(99, 0) < 70));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined datapath. It is the writer side of the IF/ID pipeline register.
- Owns the PC register and issues word fetches to instruction memory over a req/ready handshake.
- Holds each returned word in a one-entry fetch buffer and drives Instruction/PC into IF/ID.
- Generates IF/ID's IFID_writeOff (hold) and flush (bubble/NOP) controls from the hazard unit's stall and the branch-resolution redirect.

Parameters:
- PC_WIDTH, 32, width of PC, imem address and branch target.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset (0 = in reset)
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_WIDTH  fetch address, word aligned
- imem_ready  in  1  memory accepts request; imem_rdata valid in the same cycle
- imem_rdata  in  INSTR_WIDTH  fetched instruction word
- hazard_stall  in  1  ID must hold (load-use); IF/ID must not load
- branch_taken  in  1  redirect pulse from branch resolution
- branch_target  in  PC_WIDTH  redirect address; bits [1:0] ignored and forced to 0
- Instruction  out  INSTR_WIDTH  buffered instruction presented to IF/ID
- PC  out  PC_WIDTH  address of the word on Instruction
- IFID_writeOff  out  1  IF/ID hold enable
- flush  out  1  IF/ID clear (load NOP)

Behaviour:
- Reset low (async):
  - pc_reg=RESET_PC, buf_valid=0, Instruction=0, PC=0, pending=0, state=FETCH.
  - Outputs forced: imem_req=0, IFID_writeOff=0, flush=1.
  - Reset asserted mid-transaction abandons it; no response is consumed.
- Handshake:
  - A transfer completes on a cycle with imem_req=1 and imem_ready=1.
  - Once imem_req is raised without imem_ready, pending=1. While pending, imem_req stays 1 and imem_addr stays stable until imem_ready.
- Fetch buffer:
  - Instruction=buf_instr, PC=buf_pc.
  - A completed transfer in FETCH loads buf_instr<=imem_rdata, buf_pc<=imem_addr, buf_valid<=1, pc_reg<=pc_reg+4 (mod 2^PC_WIDTH, wraps at 32'hFFFF_FFFC to 0).
  - Latency: word appears on Instruction one cycle after imem_ready; IF/ID captures it at the end of that cycle.
- consume = buf_valid & ~hazard_stall & ~branch_taken. Consume clears buf_valid unless refilled the same edge.
- imem_req (FETCH) = pending | ~buf_valid | consume. With imem_ready tied 1 and no hazards, one instruction per cycle.
- Control outputs, combinational, in priority order:
  - branch_taken=1 -> flush=1, IFID_writeOff=0; buffer invalidated.
  - hazard_stall=1 -> IFID_writeOff=1, flush=0; buffer held. An empty buffer may still be filled.
  - otherwise -> IFID_writeOff=0, flush=~buf_valid (bubble when no word is ready).
- FSM states FETCH, DRAIN:
  - FETCH, branch_taken, no transfer outstanding or transfer completes this cycle -> pc_reg<=target, any returned data discarded, stay FETCH.
  - FETCH, branch_taken while imem_req=1 and imem_ready=0 -> redir_pc<=target, go DRAIN.
  - DRAIN: imem_req=1, imem_addr=old pc_reg, buffer stays empty, flush=1 unless hazard_stall.
  - DRAIN, imem_ready -> data discarded, pc_reg<=redir_pc, go FETCH.
  - DRAIN, further branch_taken -> redir_pc<=newest target; the last one wins.
  - DRAIN, branch_taken and imem_ready in the same cycle -> pc_reg<=newest target, go FETCH.
- Simultaneous hazard_stall and branch_taken: the branch wins.

Decomposition:
- Package if_pkg holds:
  - state enum {FETCH, DRAIN}
  - PC_INC=4
  - NOP_INSTR=32'h0000_0000
  - alignment mask
- Sub-module if_fetch_buffer: one-entry buffer with load/consume/invalidate. It is instantiated once; the FSM and PC logic stay in the top level.

Test Plan:
- Reset low 3 cycles, release, imem_ready=1, imem_rdata=0x0F0F0F0F,... -> imem_addr 0,4,8 on consecutive cycles; PC/Instruction show 0/0x0F0F0F0F one cycle after the first accept; flush=1 only in the first post-reset cycle.
- hazard_stall=1 for 2 cycles with PC=12 buffered -> IFID_writeOff=1, PC stays 12, Instruction unchanged, imem_req=0. After release, PC=16 follows next cycle with no word lost or duplicated.
- branch_taken with target 0x40 while the word for PC=4 is buffered -> flush=1 that cycle; next accepted address 0x40; the PC=4 word is never presented with flush=0.
- imem_ready held 0 for 3 cycles after a req at 0x8, branch_taken to 0x100 in the 2nd wait cycle -> imem_addr stays 0x8 until ready; flush=1 throughout; the next request is 0x100.
- Memory-latency bubbles: imem_ready alternating 1/0 -> flush=1 on the empty-buffer cycles; PCs presented strictly 0,4,8,...
- Reset asserted mid-DRAIN -> outputs immediately reset values; first fetch after release is RESET_PC. Separately, branch_target=0xFFFF_FFFC -> next PC wraps to 0x0.
